// File: rtl/vend_stock_fsm_if.sv
// Coin/select/stock bus around the vend transaction controller.
// master feeds the controller; slave is the controller itself.
interface vend_stock_fsm_if #(
   parameter int CREDIT_W = 5
);
   logic [3:0]          stock_in;
   logic                coin_valid;
   logic [1:0]          coin_value;
   logic                select;
   logic                cancel;
   logic                restock;
   logic [3:0]          restock_qty;
   logic [3:0]          stock_next;
   logic [CREDIT_W-1:0] credit;
   logic                dispense;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_amt;
   logic                coin_reject;
   logic                sold_out;
   logic                busy;

   modport master (
      output stock_in, coin_valid, coin_value, select,
      output cancel, restock, restock_qty,
      input  stock_next, credit, dispense, change_valid,
      input  change_amt, coin_reject, sold_out, busy
   );

   modport slave (
      input  stock_in, coin_valid, coin_value, select,
      input  cancel, restock, restock_qty,
      output stock_next, credit, dispense, change_valid,
      output change_amt, coin_reject, sold_out, busy
   );
endinterface

// File: rtl/vend_stock_fsm.sv
// Vend transaction controller: credit, select/cancel, dispense/change,
// and the next value for the downstream stock counter.
module vend_stock_fsm #(
   parameter int PRICE      = 5,
   parameter int CREDIT_W   = 5,
   parameter int MAX_CREDIT = 20
) (
   input logic             clk,
   input logic             reset,
   vend_stock_fsm_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DISPENSE,
      CHANGE
   } state_t;

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);

   state_t              state, state_n;
   logic [CREDIT_W-1:0] credit, credit_n;
   logic [CREDIT_W-1:0] chg, chg_n;
   logic [CREDIT_W-1:0] coin_amt, remain;
   logic [CREDIT_W:0]   coin_sum;
   logic [4:0]          fill;
   logic [3:0]          stock_nx;
   logic                rej, rej_n, coin_ok;

   always_comb begin
      coin_amt = '0;
      unique case (bus.coin_value)
         2'b00:   coin_amt = CREDIT_W'(1);
         2'b01:   coin_amt = CREDIT_W'(2);
         2'b10:   coin_amt = CREDIT_W'(5);
         default: coin_amt = '0;
      endcase
   end

   assign coin_ok  = bus.coin_valid && (bus.coin_value != 2'b11);
   assign coin_sum = {1'b0, credit} + {1'b0, coin_amt};
   assign remain   = credit - PRICE_C;
   assign fill     = {1'b0, bus.stock_in} + {1'b0, bus.restock_qty};

   always_comb begin
      state_n  = state;
      credit_n = credit;
      chg_n    = chg;
      rej_n    = 1'b0;
      stock_nx = bus.stock_in;
      unique case (state)
         IDLE: begin
            if (bus.restock)
               stock_nx = fill[4] ? 4'd15 : fill[3:0];
            if (coin_ok) begin
               credit_n = coin_amt;
               state_n  = COLLECT;
            end else begin
               rej_n = bus.coin_valid;
            end
         end
         COLLECT: begin
            // cancel beats select beats coin; a losing coin is refused
            if (bus.cancel) begin
               chg_n   = credit;
               state_n = CHANGE;
               rej_n   = bus.coin_valid;
            end else if (bus.select) begin
               rej_n = bus.coin_valid;
               if (credit >= PRICE_C && bus.stock_in != 4'd0)
                  state_n = DISPENSE;
            end else if (bus.coin_valid) begin
               if (coin_ok && coin_sum <= MAX_C)
                  credit_n = coin_sum[CREDIT_W-1:0];
               else
                  rej_n = 1'b1;
            end
         end
         DISPENSE: begin
            stock_nx = bus.stock_in - 4'd1;
            credit_n = remain;
            rej_n    = bus.coin_valid;
            if (remain != '0) begin
               chg_n   = remain;
               state_n = CHANGE;
            end else begin
               state_n = IDLE;
            end
         end
         CHANGE: begin
            credit_n = '0;
            rej_n    = bus.coin_valid;
            state_n  = IDLE;
         end
         default: begin
            credit_n = '0;
            state_n  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         credit <= '0;
         chg    <= '0;
         rej    <= 1'b0;
      end else begin
         state  <= state_n;
         credit <= credit_n;
         chg    <= chg_n;
         rej    <= rej_n;
      end
   end

   assign bus.stock_next   = stock_nx;
   assign bus.credit       = credit;
   assign bus.change_amt   = chg;
   assign bus.coin_reject  = rej;
   assign bus.dispense     = (state == DISPENSE);
   assign bus.change_valid = (state == CHANGE);
   assign bus.busy         = (state == DISPENSE) || (state == CHANGE);
   assign bus.sold_out     = (bus.stock_in == 4'd0);
endmodule

// File: tb/tb_vend_stock_fsm.sv
// Bench for vend_stock_fsm: transaction-level credit/stock model,
// event scoreboard and per-cycle state checks.
module tb_vend_stock_fsm;
   localparam int PRICE = 5;
   localparam int CW    = 5;
   localparam int MAXC  = 20;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   vend_stock_fsm_if #(.CREDIT_W(CW)) bus ();

   vend_stock_fsm #(
      .PRICE(PRICE), .CREDIT_W(CW), .MAX_CREDIT(MAXC)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // stand-in for the downstream stock counter, with a test preload
   logic [3:0] stk;
   logic       frc;
   logic [3:0] frc_v;
   always @(posedge clk) stk <= frc ? frc_v : bus.stock_next;
   assign bus.stock_in = stk;

   typedef struct {
      int kind;
      int amt;
      int stamp;
   } evt_t;

   evt_t sb[$];
   int   plan[$];
   int   m_cr, m_s, m_act, m_last, ecnt;
   int   n_chk, n_pass;
   bit   mon_on;

   function automatic void chk(string nm, int a, int e);
      n_chk++;
      if (a == e) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                    nm, a, e, ecnt);
   endfunction

   function automatic void pop_cmp(int k, int a);
      evt_t e;
      n_chk++;
      if (sb.size() == 0) begin
         $display("FAIL event: got kind %0d amt %0d, expected none (cycle %0d)",
                  k, a, ecnt);
         return;
      end
      e = sb.pop_front();
      if (e.kind == k && e.amt == a && e.stamp == ecnt) n_pass++;
      else $display("FAIL event: got kind %0d amt %0d cyc %0d, expected kind %0d amt %0d cyc %0d",
                    k, a, ecnt, e.kind, e.amt, e.stamp);
   endfunction

   // act/plan: 0 nothing, -1 a vend, >0 a refund of that many units
   function automatic void model(bit cv, logic [1:0] cval, bit sel,
                                 bit can, bit rs, logic [3:0] q);
      int v;
      bit rej;
      v = (cval == 2'd0) ? 1 : (cval == 2'd1) ? 2 : (cval == 2'd2) ? 5 : 0;
      rej = 1'b0;
      if (m_act != 0) begin
         if (m_act < 0) begin
            m_s  = m_s - 1;
            m_cr = m_cr - PRICE;
         end else begin
            m_cr = 0;
         end
         rej = cv;
      end else if (m_cr == 0) begin
         if (rs) m_s = (m_s + int'(q) > 15) ? 15 : m_s + int'(q);
         if (cv) begin
            if (v == 0) rej = 1'b1;
            else m_cr = v;
         end
      end else if (can) begin
         plan.push_back(m_cr);
         rej = cv;
      end else if (sel) begin
         rej = cv;
         if (m_cr >= PRICE && m_s > 0) begin
            plan.push_back(-1);
            if (m_cr > PRICE) plan.push_back(m_cr - PRICE);
         end
      end else if (cv) begin
         if (v > 0 && m_cr + v <= MAXC) m_cr = m_cr + v;
         else rej = 1'b1;
      end
      m_act = (plan.size() > 0) ? plan.pop_front() : 0;
      if (rej) sb.push_back('{0, 0, ecnt});
      if (m_act < 0) sb.push_back('{1, 0, ecnt});
      if (m_act > 0) begin
         sb.push_back('{2, m_act, ecnt});
         m_last = m_act;
      end
   endfunction

   always @(negedge clk) begin
      if (mon_on) begin
         chk("credit", int'(bus.credit), m_cr);
         chk("stock", int'(stk), m_s);
         chk("sold_out", int'(bus.sold_out), int'(m_s == 0));
         chk("busy", int'(bus.busy), int'(m_act != 0));
         chk("change_amt_hold", int'(bus.change_amt), m_last);
         while (sb.size() > 0 && sb[0].stamp < ecnt) begin
            n_chk++;
            $display("FAIL missing_event: got none, expected kind %0d amt %0d cyc %0d",
                     sb[0].kind, sb[0].amt, sb[0].stamp);
            void'(sb.pop_front());
         end
         if (bus.coin_reject) pop_cmp(0, 0);
         if (bus.dispense) pop_cmp(1, 0);
         if (bus.change_valid) pop_cmp(2, int'(bus.change_amt));
      end
   end

   task automatic tick(bit cv, logic [1:0] cval, bit sel, bit can,
                       bit rs, logic [3:0] q, bit fe, logic [3:0] fv);
      bus.coin_valid  = cv;
      bus.coin_value  = cval;
      bus.select      = sel;
      bus.cancel      = can;
      bus.restock     = rs;
      bus.restock_qty = q;
      frc             = fe;
      frc_v           = fv;
      @(posedge clk);
      ecnt++;
      if (reset) model(cv, cval, sel, can, rs, q);
      if (fe) m_s = int'(fv);
      #1;
      bus.coin_valid = 1'b0;
      bus.select     = 1'b0;
      bus.cancel     = 1'b0;
      bus.restock    = 1'b0;
      frc            = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) tick(0, 2'd0, 0, 0, 0, 4'd0, 0, 4'd0);
   endtask

   task automatic coin(logic [1:0] c);
      tick(1, c, 0, 0, 0, 4'd0, 0, 4'd0);
   endtask

   task automatic sel();
      tick(0, 2'd0, 1, 0, 0, 4'd0, 0, 4'd0);
   endtask

   task automatic can();
      tick(0, 2'd0, 0, 1, 0, 4'd0, 0, 4'd0);
   endtask

   task automatic preload(logic [3:0] v);
      tick(0, 2'd0, 0, 0, 0, 4'd0, 1, v);
   endtask

   task automatic do_reset();
      reset  = 1'b0;
      m_cr   = 0;
      m_act  = 0;
      m_last = 0;
      plan.delete();
      while (sb.size() > 0 && sb[sb.size()-1].stamp >= ecnt)
         void'(sb.pop_back());
      idle(1);
      reset = 1'b1;
   endtask

   initial begin
      bus.coin_valid  = 1'b0;
      bus.coin_value  = 2'd0;
      bus.select      = 1'b0;
      bus.cancel      = 1'b0;
      bus.restock     = 1'b0;
      bus.restock_qty = 4'd0;
      frc             = 1'b0;
      frc_v           = 4'd0;
      #2;
      preload(4'd3);
      mon_on = 1'b1;
      idle(1);
      reset = 1'b1;
      idle(1);

      // exact pay
      coin(2'b10); sel(); idle(3);
      // overpay, change of 5
      preload(4'd3);
      coin(2'b10); coin(2'b10); sel(); idle(3);
      // cancel beats select and a coin in the same cycle
      coin(2'b01); coin(2'b00);
      tick(1, 2'b00, 1, 1, 0, 4'd0, 0, 4'd0);
      idle(2);
      // sold out, then underpay
      preload(4'd0);
      coin(2'b10); sel(); idle(1); can(); idle(2);
      preload(4'd3);
      coin(2'b01); sel(); idle(1); can(); idle(2);
      // credit ceiling and the invalid coin code
      repeat (4) coin(2'b10);
      coin(2'b00); coin(2'b11); idle(1); can(); idle(2);
      // restock saturation in IDLE, ignored in COLLECT
      preload(4'd12);
      tick(0, 2'd0, 0, 0, 1, 4'd6, 0, 4'd0); idle(1);
      preload(4'd12);
      coin(2'b10);
      tick(0, 2'd0, 0, 0, 1, 4'd6, 0, 4'd0);
      can(); idle(2);
      // reset while dispensing
      coin(2'b10); coin(2'b10); sel();
      do_reset();
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            tick($urandom_range(0, 9) < 4,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 2,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) == 0,
                 4'($urandom_range(0, 15)),
                 0, 4'd0);
         end
      end

      idle(4);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/vend_stock_fsm.md
Name: vend_stock_fsm

Overview:
Transaction controller directly upstream of the per-product stock counter register. Accepts coins, tracks credit and handles select/cancel. Computes the next stock value that the counter loads every clock: decrement on a vend, saturating add on restock, otherwise unchanged. Also issues dispense and change pulses to the actuator/change-return logic.

Parameters:
PRICE, 5, product price in credit units; must be 1..MAX_CREDIT
CREDIT_W, 5, width of credit and change_amt
MAX_CREDIT, 20, highest credit accepted; must be < 2^CREDIT_W

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
stock_in  in  4  current stock, from the stock counter's registered output
coin_valid  in  1  one-cycle strobe, coin present
coin_value  in  2  00=1, 01=2, 10=5, 11=invalid
select  in  1  one-cycle vend request
cancel  in  1  one-cycle refund request
restock  in  1  one-cycle restock strobe
restock_qty  in  4  units to add on restock
stock_next  out  4  next stock; drives the counter's count input
credit  out  CREDIT_W  accumulated credit
dispense  out  1  high for exactly one cycle per vend
change_valid  out  1  high for one cycle when change_amt is valid
change_amt  out  CREDIT_W  amount returned
coin_reject  out  1  one-cycle pulse; coin was not accepted
sold_out  out  1  stock_in == 0, combinational
busy  out  1  state is DISPENSE or CHANGE

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low on port reset.
- Reset values: state=IDLE, credit=0, change_amt=0, dispense=0, change_valid=0, coin_reject=0, busy=0.
- stock_next is combinational and reset-independent. The downstream counter loads it every edge, so default stock_next = stock_in.
- States: IDLE, COLLECT, DISPENSE, CHANGE. All outputs except stock_next and sold_out are registered or decoded from registered state.
- IDLE (credit=0):
  - Valid coin: credit<=value, go to COLLECT.
  - restock: stock_next = min(stock_in+restock_qty, 15) in that same cycle.
  - select and cancel are ignored.
- COLLECT: per-cycle priority is cancel > select > coin.
  - cancel: go to CHANGE with change amount = credit.
  - select with credit>=PRICE and stock_in!=0: go to DISPENSE.
  - select with credit<PRICE, or with stock_in==0: ignored, stay in COLLECT.
  - Coin alone: credit<=credit+value if the sum is <= MAX_CREDIT; otherwise credit is unchanged and coin_reject pulses.
  - restock: ignored.
- DISPENSE (1 cycle):
  - dispense=1 and stock_next=stock_in-1.
  - credit<=credit-PRICE.
  - Next state is CHANGE if the remainder is >0, else IDLE.
- CHANGE (1 cycle):
  - change_valid=1 and change_amt=credit.
  - credit<=0, go to IDLE.
  - change_amt holds its value afterwards until the next CHANGE.
- Invalid coins: any coin with value 11 in any state is rejected, as is any coin that loses arbitration to cancel/select or arrives in DISPENSE/CHANGE. Each rejected coin gives a coin_reject pulse one cycle after the strobe, and credit is unchanged.
- Latency: select sampled at edge k gives dispense high during cycle k..k+1, and the stock counter shows stock-1 after edge k+1. A change pulse follows one cycle after dispense.
- No underflow: DISPENSE is unreachable with stock_in==0. Restock saturates at 15 and never wraps.
- Reset mid-transaction: credit is discarded, and no dispense or change is issued. stock_next immediately reverts to stock_in.

Test Plan:
- Exact pay: reset, stock 3; coin 5 then select -> one dispense pulse, stock 3->2, credit 0, no change_valid, state IDLE.
- Overpay with change: coins 5,5 then select -> dispense, next cycle change_valid with change_amt=5, stock decremented once.
- Cancel and priority: coins 2,1, then cancel+select+coin in the same cycle -> change_amt=3, no dispense, coin_reject pulse, stock unchanged.
- Sold out and underpay: stock 0, coin 5, select -> no dispense, sold_out=1, credit 5 retained. With stock 3, coin 2 then select -> ignored.
- Credit limit and invalid coin: 4x coin 5 (credit 20), then coin 1 -> rejected. Coin 11 -> rejected. Credit stays 20.
- Restock: IDLE with stock 12, restock qty 6 -> stock 15 (saturated). The same restock during COLLECT -> ignored. Reset asserted in DISPENSE -> no change pulse, credit 0.
